// File: rtl/fmdll_pkg.sv
// Shared constants for the FMDLL N/M counter slice: default widths, FSM state codes, Sel codes.
// Pure declarations; no clocked logic.
// No handshake of its own.
package fmdll_pkg;

  localparam int FMDLL_NW = 4;
  localparam int FMDLL_MW = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  localparam logic [1:0] SEL_FB  = 2'b00;
  localparam logic [1:0] SEL_REF = 2'b01;
  localparam logic [1:0] SEL_ARM = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  // REF may only be chosen while the outer count sits on its last frame cycle group.
  function automatic logic sel_illegal(input logic [1:0] sel, input logic at_last_m);
    case (sel)
      SEL_FB, SEL_ARM: return 1'b0;
      SEL_REF:         return !at_last_m;
      default:         return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fmdll_cfg_shadow.sv
// N/M configuration intake: valid/ready handshake, zero-to-one clamping, shadow and active ratio registers.
// Latency: a capture lands in active or shadow on the same edge; shadow reaches active at the next frame end.
// Backpressure: cfg_ready is low while a shadow ratio is waiting for its frame boundary.
module fmdll_cfg_shadow
  import fmdll_pkg::*;
#(
  parameter int NW = FMDLL_NW,
  parameter int MW = FMDLL_MW
) (
  input  logic          clk_out,
  input  logic          rst_n,
  input  logic [NW-1:0] N,
  input  logic [MW-1:0] M,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic          pend,
  input  logic          apply_now,
  output logic          capture,
  output logic [NW-1:0] n_act,
  output logic [MW-1:0] m_act
);

  localparam logic [NW-1:0] N_ONE = {{(NW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0] M_ONE = {{(MW-1){1'b0}}, 1'b1};

  logic [NW-1:0] n_shd;
  logic [MW-1:0] m_shd;
  logic [NW-1:0] n_clamp;
  logic [MW-1:0] m_clamp;

  assign cfg_ready = !pend;
  assign capture   = cfg_valid && cfg_ready;
  assign n_clamp   = (N == '0) ? N_ONE : N;
  assign m_clamp   = (M == '0) ? M_ONE : M;

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      n_act <= N_ONE;
      m_act <= M_ONE;
      n_shd <= N_ONE;
      m_shd <= M_ONE;
    end else if (capture && apply_now) begin
      n_act <= n_clamp;
      m_act <= m_clamp;
    end else if (capture) begin
      n_shd <= n_clamp;
      m_shd <= m_clamp;
    end else if (pend && apply_now) begin
      n_act <= n_shd;
      m_act <= m_shd;
    end
  end

endmodule

// File: rtl/fmdll_nm_counter.sv
// 1-based N/M cycle counters and DIV_N/DIV_M/frame_start strobes for the FMDLL select logic, with Sel monitor.
// Latency: counters registered; DIV_N/DIV_M decoded from them in the same cycle; frame_start registered.
// Backpressure: cfg_ready drops while a ratio change waits for the frame end; held cfg_valid is ignored meanwhile.
module fmdll_nm_counter
  import fmdll_pkg::*;
#(
  parameter int NW = FMDLL_NW,
  parameter int MW = FMDLL_MW
) (
  input  logic          clk_out,
  input  logic          rst_n,
  input  logic [NW-1:0] N,
  input  logic [MW-1:0] M,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    Sel,
  output logic [NW-1:0] N_counter,
  output logic [MW-1:0] M_counter,
  output logic          DIV_N,
  output logic          DIV_M,
  output logic          frame_start,
  output logic          sel_err
);

  localparam logic [NW-1:0] N_ONE = {{(NW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0] M_ONE = {{(MW-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [NW-1:0] n_act;
  logic [MW-1:0] m_act;
  logic          capture;
  logic          running;
  logic          n_wrap;
  logic          m_wrap;

  assign running = (state != IDLE);
  assign DIV_N   = running && (N_counter == n_act);
  assign DIV_M   = DIV_N && (M_counter == m_act);
  // >= so a counter left above a freshly shrunk ratio still wraps
  assign n_wrap  = (N_counter >= n_act);
  assign m_wrap  = (M_counter >= m_act);

  fmdll_cfg_shadow #(.NW(NW), .MW(MW)) u_cfg (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .N         (N),
    .M         (M),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .pend      (state == PEND),
    .apply_now ((state == IDLE) || DIV_M),
    .capture   (capture),
    .n_act     (n_act),
    .m_act     (m_act)
  );

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state       <= IDLE;
      N_counter   <= N_ONE;
      M_counter   <= M_ONE;
      frame_start <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          N_counter   <= N_ONE;
          M_counter   <= M_ONE;
          frame_start <= capture;
          if (capture) state <= RUN;
        end
        RUN, PEND: begin
          if (n_wrap) begin
            N_counter <= N_ONE;
            M_counter <= m_wrap ? M_ONE : M_counter + 1'b1;
          end else begin
            N_counter <= N_counter + 1'b1;
          end
          frame_start <= n_wrap && m_wrap;
          if (sel_illegal(Sel, M_counter == m_act)) sel_err <= 1'b1;
          if (state == RUN && capture && !DIV_M) state <= PEND;
          else if (state == PEND && DIV_M)       state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmdll_nm_counter.sv
// Directed vector bench for fmdll_nm_counter: a main table plus short sequences for Sel and reset-in-PEND.
module tb_fmdll_nm_counter;

  logic       clk_out = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] N = '0;
  logic [1:0] M = '0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] Sel = '0;
  logic [3:0] N_counter;
  logic [1:0] M_counter;
  logic       DIV_N, DIV_M, frame_start, sel_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_out = ~clk_out;

  fmdll_nm_counter #(.NW(4), .MW(2)) dut (
    .clk_out     (clk_out),
    .rst_n       (rst_n),
    .N           (N),
    .M           (M),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .Sel         (Sel),
    .N_counter   (N_counter),
    .M_counter   (M_counter),
    .DIV_N       (DIV_N),
    .DIV_M       (DIV_M),
    .frame_start (frame_start),
    .sel_err     (sel_err)
  );

  typedef struct {
    logic       rst_n;
    logic       vld;
    logic [3:0] n;
    logic [1:0] m;
    logic [1:0] sel;
    logic [3:0] en;
    logic [1:0] em;
    logic       dn, dm, fs, rdy, err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] n, input logic [1:0] m,
                              input logic [1:0] s, input logic [3:0] en, input logic [1:0] em,
                              input logic dn, input logic dm, input logic fs, input logic rdy,
                              input logic err);
    vec_t x;
    x.rst_n = r; x.vld = v; x.n = n; x.m = m; x.sel = s;
    x.en = en; x.em = em; x.dn = dn; x.dm = dm; x.fs = fs; x.rdy = rdy; x.err = err;
    return x;
  endfunction

  // Drive one vector's inputs, take one edge, then compare all outputs 1 ns later.
  task automatic run(input string tag, input int idx, input vec_t v);
    logic [10:0] got, exp;
    rst_n = v.rst_n; cfg_valid = v.vld; N = v.n; M = v.m; Sel = v.sel;
    @(posedge clk_out);
    #1;
    got = {N_counter, M_counter, DIV_N, DIV_M, frame_start, cfg_ready, sel_err};
    exp = {v.en, v.em, v.dn, v.dm, v.fs, v.rdy, v.err};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got n=%0d m=%0d dn=%b dm=%b fs=%b rdy=%b err=%b, want n=%0d m=%0d dn=%b dm=%b fs=%b rdy=%b err=%b",
               tag, idx, N_counter, M_counter, DIV_N, DIV_M, frame_start, cfg_ready, sel_err,
               v.en, v.em, v.dn, v.dm, v.fs, v.rdy, v.err);
    end
  endtask

  vec_t tbl[$];
  vec_t sel_seq[$];
  vec_t rst_seq[$];

  initial begin
    // fields: rst_n vld N M Sel | N_counter M_counter DIV_N DIV_M frame_start cfg_ready sel_err
    tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,0,1,0));
    tbl.push_back(mk(1,1,4,2,0, 1,1,0,0,1,1,0));
    tbl.push_back(mk(1,0,0,0,0, 2,1,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0, 3,1,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0, 4,1,1,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,2,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,1, 2,2,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,1, 3,2,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,1, 4,2,1,1,0,1,0));
    tbl.push_back(mk(1,0,0,0,1, 1,1,0,0,1,1,0));
    tbl.push_back(mk(1,0,0,0,0, 2,1,0,0,0,1,0));
    // mid-frame request goes to shadow; the held 7/1 request must be ignored
    tbl.push_back(mk(1,1,3,3,0, 3,1,0,0,0,0,0));
    tbl.push_back(mk(1,1,7,1,0, 4,1,1,0,0,0,0));
    tbl.push_back(mk(1,1,7,1,0, 1,2,0,0,0,0,0));
    tbl.push_back(mk(1,1,7,1,0, 2,2,0,0,0,0,0));
    tbl.push_back(mk(1,1,7,1,0, 3,2,0,0,0,0,0));
    tbl.push_back(mk(1,1,7,1,0, 4,2,1,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0,0,1,1,0));
    for (int f = 0; f < 2; f++) begin
      tbl.push_back(mk(1,0,0,0,0, 2,1,0,0,0,1,0));
      tbl.push_back(mk(1,0,0,0,0, 3,1,1,0,0,1,0));
      tbl.push_back(mk(1,0,0,0,0, 1,2,0,0,0,1,0));
      tbl.push_back(mk(1,0,0,0,0, 2,2,0,0,0,1,0));
      tbl.push_back(mk(1,0,0,0,0, 3,2,1,0,0,1,0));
      tbl.push_back(mk(1,0,0,0,0, 1,3,0,0,0,1,0));
      tbl.push_back(mk(1,0,0,0,0, 2,3,0,0,0,1,0));
      tbl.push_back(mk(1,0,0,0,0, 3,3,1,1,0,1,0));
      if (f == 0) tbl.push_back(mk(1,0,0,0,0, 1,1,0,0,1,1,0));
    end
    // request on the DIV_M cycle applies at once
    tbl.push_back(mk(1,1,2,1,0, 1,1,0,0,1,1,0));
    tbl.push_back(mk(1,0,0,0,0, 2,1,1,1,0,1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0,0,1,1,0));
    tbl.push_back(mk(1,0,0,0,0, 2,1,1,1,0,1,0));
    // 0/0 clamps to 1/1: every strobe high every cycle
    tbl.push_back(mk(1,1,0,0,0, 1,1,1,1,1,1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,1,1,1,1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,1,1,1,1,0));

    sel_seq.push_back(mk(0,0,0,0,3, 1,1,0,0,0,1,0));
    sel_seq.push_back(mk(1,0,0,0,3, 1,1,0,0,0,1,0));
    sel_seq.push_back(mk(1,1,4,2,0, 1,1,0,0,1,1,0));
    sel_seq.push_back(mk(1,0,0,0,1, 2,1,0,0,0,1,1));
    sel_seq.push_back(mk(1,0,0,0,0, 3,1,0,0,0,1,1));
    sel_seq.push_back(mk(1,0,0,0,0, 4,1,1,0,0,1,1));
    sel_seq.push_back(mk(1,0,0,0,0, 1,2,0,0,0,1,1));
    sel_seq.push_back(mk(0,0,0,0,0, 1,1,0,0,0,1,0));
    sel_seq.push_back(mk(1,1,4,2,0, 1,1,0,0,1,1,0));
    sel_seq.push_back(mk(1,0,0,0,3, 2,1,0,0,0,1,1));
    sel_seq.push_back(mk(1,0,0,0,0, 3,1,0,0,0,1,1));

    rst_seq.push_back(mk(0,0,0,0,0, 1,1,0,0,0,1,0));
    rst_seq.push_back(mk(1,1,4,2,0, 1,1,0,0,1,1,0));
    rst_seq.push_back(mk(1,0,0,0,0, 2,1,0,0,0,1,0));
    rst_seq.push_back(mk(1,1,3,3,0, 3,1,0,0,0,0,0));
    rst_seq.push_back(mk(0,1,3,3,0, 1,1,0,0,0,1,0));
    rst_seq.push_back(mk(1,0,0,0,0, 1,1,0,0,0,1,0));
    rst_seq.push_back(mk(1,0,0,0,0, 1,1,0,0,0,1,0));
    rst_seq.push_back(mk(1,1,2,1,0, 1,1,0,0,1,1,0));
    rst_seq.push_back(mk(1,0,0,0,0, 2,1,1,1,0,1,0));
    rst_seq.push_back(mk(1,0,0,0,0, 1,1,0,0,1,1,0));
    rst_seq.push_back(mk(1,0,0,0,0, 2,1,1,1,0,1,0));

    foreach (tbl[i])     run("main", i, tbl[i]);
    foreach (sel_seq[i]) run("sel", i, sel_seq[i]);
    foreach (rst_seq[i]) run("rst_pend", i, rst_seq[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fmdll_nm_counter.md
Name: fmdll_nm_counter

Overview:
- Generates the 1-based N/M cycle counters and the divider strobes that the FMDLL select logic consumes.
- Counts output-clock cycles from 1 to N for the inner count, and frames of N cycles from 1 to M for the outer count.
- Accepts new N/M ratios through a valid/ready handshake and applies them only at a frame boundary.
- Monitors the returned Sel code and flags illegal selections.
- Sits between the configuration interface and the select/mux logic of the delay line.

Parameters:
- NW, 4, width of N and N_counter.
- MW, 2, width of M and M_counter.

Ports:
- clk_out  in  1  output clock of the delay line; the only clock.
- rst_n  in  1  synchronous reset, active-low.
- N  in  NW  requested inner divide ratio; 0 is treated as 1.
- M  in  MW  requested outer frame count; 0 is treated as 1.
- cfg_valid  in  1  N/M present on the inputs.
- cfg_ready  out  1  block can accept N/M.
- Sel  in  2  select code returned from the select logic.
- N_counter  out  NW  inner count, range 1..N.
- M_counter  out  MW  outer count, range 1..M.
- DIV_N  out  1  high while N_counter == active N.
- DIV_M  out  1  high while N_counter == active N and M_counter == active M.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- sel_err  out  1  sticky flag for an illegal Sel.

Behaviour:
- One clock, clk_out. Reset is synchronous and active-low on rst_n; it is sampled only at the clk_out rising edge.
- Reset values:
  - N_counter = 1, M_counter = 1.
  - Active N = 1, active M = 1; shadow N = 1, shadow M = 1.
  - DIV_N = 0, DIV_M = 0, frame_start = 0, sel_err = 0, cfg_ready = 1.
  - State = IDLE.
- A reset asserted mid-operation has the same effect on the next edge. Any pending configuration is discarded.
- Clamping: a 0 on N or M is stored as 1 at capture time.
- FSM states:
  - IDLE: counters held at 1/1, strobes low, cfg_ready = 1. A cfg_valid&&cfg_ready capture loads the active registers directly, and the next cycle enters RUN with frame_start = 1.
  - RUN: counting; cfg_ready = 1. A capture on a frame-end cycle (DIV_M = 1) loads the active registers directly and the state stays RUN. A capture on any other cycle loads the shadow registers and moves to PEND.
  - PEND: cfg_ready = 0. At the frame-end cycle the shadow values are copied to active, then the state returns to RUN.
- Counting (RUN and PEND), evaluated each edge:
  - If N_counter >= active N: N_counter <= 1.
    - If M_counter >= active M, M_counter <= 1; otherwise M_counter <= M_counter + 1.
  - Otherwise N_counter <= N_counter + 1.
  - The >= comparison guards against a counter exceeding the active value after a ratio change.
- Strobes:
  - DIV_N and DIV_M are combinational decodes of the registered counters against the active values, so they are glitch-free relative to clk_out.
  - frame_start is registered. It is high in the cycle where N_counter == 1 and M_counter == 1, following a wrap or the IDLE exit.
- Degenerate ratios:
  - N = 1: N_counter stays at 1, DIV_N is constantly high, and M advances every cycle.
  - N = 1 and M = 1: DIV_M and frame_start are high every cycle.
- Handshake: a transfer occurs when cfg_valid and cfg_ready are both high at an edge. cfg_valid held in PEND is ignored until cfg_ready returns.
- New ratios take effect on the cycle after the frame end. The first cycle of the new frame uses the new N and M with counters at 1/1.
- Sel monitor, evaluated in RUN and PEND only. sel_err is set and held until reset when either holds at an edge:
  - Sel == 2'b11.
  - Sel == 2'b01 while M_counter != active M.

Decomposition:
- Shared package fmdll_pkg holds:
  - State enum: IDLE, RUN, PEND.
  - Sel code constants: SEL_FB = 2'b00, SEL_REF = 2'b01, SEL_ARM = 2'b10, SEL_BAD = 2'b11.
  - Default widths NW and MW.
- One natural sub-module, fmdll_cfg_shadow: the handshake plus the shadow and active registers with clamping.
- The counter and FSM stay in the top module.

Test Plan:
- Reset, then capture N = 4, M = 2 from IDLE:
  - N_counter sequence 1,2,3,4,1,2,3,4,1…
  - M_counter 1,1,1,1,2,2,2,2,1.
  - DIV_N high on every N_counter = 4 cycle; DIV_M high only on the 8th cycle.
  - frame_start high on cycles 1 and 9.
- In RUN with N = 4, M = 2, present N = 3, M = 3 at N_counter = 2, M_counter = 1:
  - cfg_ready drops the next cycle.
  - The old frame completes (DIV_M on 4/2).
  - The next frame counts 1..3 three times; cfg_ready returns to 1 after the boundary.
- Present N = 0, M = 0:
  - Behaves as 1/1: DIV_N, DIV_M and frame_start are high every cycle.
- Drive Sel = 2'b01 at M_counter = 1 with M = 2:
  - sel_err = 1 the next cycle and stays 1 until rst_n is pulsed low.
  - With Sel = 2'b01 at M_counter = 2, sel_err stays 0.
- Assert rst_n = 0 for one edge while in PEND at N_counter = 3:
  - Next cycle shows counters 1/1, state IDLE, cfg_ready = 1, all strobes 0.
  - The shadow configuration is lost.
- Present cfg_valid exactly on the DIV_M cycle with N = 2, M = 1:
  - Applied immediately and the state stays RUN.
  - The next cycle starts at 1/1 with the new ratio; cfg_ready never drops.
